// File: rtl/riscv.sv
// Shared RISC-V fetch-side types and constants.
// fetch_entry_t pairs a fetched word with the PC it was read from.
package riscv;

  localparam int RV_XLEN = 32;

  typedef logic [RV_XLEN-1:0] pc_t;
  typedef logic [RV_XLEN-1:0] ir_t;

  // addi x0, x0, 0 -- presented to decode whenever no instruction is available
  localparam ir_t NOP = 32'h0000_0013;

  typedef struct packed {
    pc_t pc;
    ir_t ir;
  } fetch_entry_t;

  // Word-align a control-transfer target (low two bits are not part of the address)
  function automatic pc_t align_word(input pc_t target);
    return {target[RV_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding fetched {pc, ir} entries.
// The head is read straight out of storage so decode sees it with no extra
// latency. Flush clears pointers and count in one cycle; storage is left as is.
module sync_fifo
  import riscv::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = riscv::fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output entry_t                 head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t         storage [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           pop_ok;
  logic           push_ok;

  // Popping an empty queue is ignored; a push into a full queue is only
  // accepted when the head leaves in the same cycle.
  assign pop_ok  = pop & (count != '0);
  assign push_ok = push & ((count != CW'(DEPTH)) | pop_ok);

  assign head = storage[rd_ptr];

  // Storage write port (no reset needed: entries are qualified by count)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush empty the queue
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue.
// Issues one imem read per cycle while queue occupancy plus the in-flight
// read leaves room, so every returning word always has a slot. A redirect
// flushes the queue, drops the in-flight word and restarts at the target.
// Optional build macro FETCH_QUEUE_PERF_EN adds fetched/flushed/stall
// performance counters; without it those ports do not exist.
module fetch_queue
  import riscv::*;
#(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h2000,
  parameter int             DEPTH    = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_ir
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } entry_t;

  logic [XLEN-1:0] fpc;
  logic            pend;
  logic [XLEN-1:0] pend_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   occupancy;
  logic            push;
  logic            pop;
  entry_t          push_data;
  entry_t          head;
  logic            unused_redirect_lsb;

  // The low address bits of a target never reach the fetch PC
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit: queued entries plus the read still in flight must stay below DEPTH
  // before another read may be issued.
  assign occupancy = count + CW'(pend);
  assign mem_req   = resetn & ~redirect & (occupancy < CW'(DEPTH));
  assign mem_addr  = fpc;

  // The word returning this cycle belongs to pend_pc unless it is being flushed
  assign push           = pend & resetn & ~redirect;
  assign push_data.pc   = pend_pc;
  assign push_data.ir   = mem_rdata;
  assign pop            = out_valid & out_ready;

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_ir    = out_valid ? head.ir : XLEN'(NOP);

  sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  // Fetch PC and in-flight tracking; redirect overrides any issue decision
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fpc     <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else if (redirect) begin
      fpc     <= {redirect_pc[XLEN-1:2], 2'b00};
      pend    <= 1'b0;
    end else begin
      // A read issued now is in flight next cycle; otherwise the previous
      // one has just returned and nothing is outstanding.
      pend <= mem_req;
      if (mem_req) begin
        fpc     <= fpc + XLEN'(4);
        pend_pc <= fpc;
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [CW-1:0] discarded;

  // Entries lost on a redirect: the queue minus any head the consumer took
  // this cycle, plus the read whose data is dropped.
  assign discarded = count - CW'(pop) + CW'(pend);

  // Performance counters, free-running and wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect) begin
        perf_flushed <= perf_flushed + 32'(discarded);
      end
      if (!redirect && !mem_req) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed vector table, hand-written
// redirect/perf sequences, and randomized traffic against a queue-based model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn, redirect, out_ready;
  logic [31:0] redirect_pc;
  logic        mem_req, out_valid;
  logic [31:0] mem_addr, mem_rdata, out_pc, out_ir;

  logic        resetn2;
  logic        mem_req2, out_valid2;
  logic [31:0] mem_addr2, mem_rdata2, out_pc2, out_ir2;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stall;
  logic [31:0] unused_pf2, unused_pl2, unused_ps2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .RESET_PC(32'h2000), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stall(perf_stall)
`endif
  );

  fetch_queue #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .resetn(resetn2), .redirect(1'b0), .redirect_pc(32'h0),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_pc(out_pc2), .out_ir(out_ir2)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_fetched(unused_pf2), .perf_flushed(unused_pl2), .perf_stall(unused_ps2)
`endif
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hFFFF_0000;
  endfunction

  // Fixed one-cycle-latency instruction memory; garbage when not requested
  always @(posedge clk) begin
    mem_rdata  <= mem_req  ? imem(mem_addr)  : 32'hDEAD_BEEF;
    mem_rdata2 <= mem_req2 ? imem(mem_addr2) : 32'hDEAD_BEEF;
  end

  // Capture the first four deliveries of the wrapping instance
  logic [31:0] cap_pc[$];
  logic [31:0] cap_ir[$];
  always @(negedge clk) begin
    if (resetn2 === 1'b1 && out_valid2 === 1'b1 && cap_pc.size() < 4) begin
      cap_pc.push_back(out_pc2);
      cap_ir.push_back(out_ir2);
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ment_t;
  ment_t       mq[$];
  logic [31:0] m_fpc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_fetched, m_flushed, m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend    = 0;
    m_pend_pc = '0;
    m_fpc     = 32'h2000;
    m_fetched = 0;
    m_flushed = 0;
    m_stall   = 0;
  endtask

  task automatic drive(input logic rn, input logic rd, input logic [31:0] rpc, input logic rdy);
    resetn      = rn;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
  endtask

  // Compare DUT against the model for the current cycle, then advance both
  task automatic settle();
    bit   e_valid, e_req, pop;
    int   occ;
    e_valid = (mq.size() != 0);
    occ     = mq.size() + int'(m_pend);
    e_req   = resetn && !redirect && (occ < DEPTH);
    pop     = e_valid && out_ready;
    chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
    chk("mem_addr", mem_addr, m_fpc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
    if (e_valid) chk("out_pc", out_pc, mq[0].pc);
    chk("out_ir", out_ir, e_valid ? mq[0].ir : NOP_W);
`ifdef FETCH_QUEUE_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_flushed", perf_flushed, m_flushed);
    chk("perf_stall", perf_stall, m_stall);
`endif
    if (!resetn) begin
      model_reset();
    end else if (redirect) begin
      m_flushed += 32'(mq.size() - int'(pop) + int'(m_pend));
      mq.delete();
      m_pend = 0;
      m_fpc  = redirect_pc & ~32'h3;
    end else begin
      if (!e_req) m_stall++;
      if (pop) void'(mq.pop_front());
      if (m_pend) begin
        mq.push_back('{m_pend_pc, imem(m_pend_pc)});
        m_fetched++;
      end
      if (e_req) begin
        m_pend_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
        m_pend    = 1;
      end else begin
        m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    settle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int          n, nreq, obs_stall;
    bit          found;
    logic        rn, rd, rdy, stale;
    logic [31:0] rpc, exp_pc;

    tbl[0]  = '{1'b0, 1'b1, 32'h2000, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h2004, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h2008, 1'b1, 32'h2000};
    tbl[3]  = '{1'b0, 1'b1, 32'h200C, 1'b1, 32'h2000};
    for (int i = 4; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 32'h2010, 1'b1, 32'h2000};
    tbl[10] = '{1'b1, 1'b0, 32'h2010, 1'b1, 32'h2000};
    tbl[11] = '{1'b1, 1'b1, 32'h2010, 1'b1, 32'h2004};
    tbl[12] = '{1'b1, 1'b1, 32'h2014, 1'b1, 32'h2008};
    tbl[13] = '{1'b1, 1'b1, 32'h2018, 1'b1, 32'h200C};
    tbl[14] = '{1'b1, 1'b1, 32'h201C, 1'b1, 32'h2010};
    tbl[15] = '{1'b1, 1'b1, 32'h2020, 1'b1, 32'h2014};

    // Unchecked power-on reset brings the DUTs to a known state
    resetn2 = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset values
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("reset_mem_req", {31'b0, mem_req}, 32'h0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_out_ir", out_ir, NOP_W);
    settle();
    resetn2 = 1'b1;

    // Reset release with out_ready=1: first delivery latency and stream
    n = 0;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      if (out_valid === 1'b1) found = 1;
      else begin settle(); n++; end
    end
    chk("first_valid_found", {31'b0, found}, 32'h1);
    chk("first_valid_latency", 32'(n), 32'd2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) drive(1'b1, 1'b0, 32'h0, 1'b1);
      chk("stream_valid", {31'b0, out_valid}, 32'h1);
      chk("stream_pc", out_pc, 32'h2000 + 32'(4 * k));
      $display("stream %0d: pc=%h ir=%h", k, out_pc, out_ir);
      settle();
    end

    // Backpressure table: fill to DEPTH, stall, drain in order, resume
    do_reset();
    nreq = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'h0, tbl[i].rdy);
      chk("vec_req", {31'b0, mem_req}, {31'b0, tbl[i].e_req});
      chk("vec_addr", mem_addr, tbl[i].e_addr);
      chk("vec_valid", {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) chk("vec_pc", out_pc, tbl[i].e_pc);
      if (i < 10 && mem_req === 1'b1) nreq++;
      $display("vec %0d: rdy=%0b req=%0b addr=%h valid=%0b pc=%h", i, tbl[i].rdy, mem_req, mem_addr, out_valid, out_pc);
      settle();
    end
    chk("stalled_req_count", 32'(nreq), 32'd4);

    // Redirect with 3 queued entries and a pending read
    do_reset();
    repeat (4) begin drive(1'b1, 1'b0, 32'h0, 1'b0); settle(); end
    drive(1'b1, 1'b1, 32'h3002, 1'b0);
    chk("redirect_req_low", {31'b0, mem_req}, 32'h0);
    $display("redirect to %h", redirect_pc);
    settle();
    n = 0;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      if (out_valid === 1'b1) found = 1;
      else begin settle(); n++; end
    end
    chk("redir_valid_found", {31'b0, found}, 32'h1);
    chk("redir_latency", 32'(n), 32'd2);
    chk("redir_target_pc", out_pc, 32'h3000);
    settle();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'($urandom_range(0, 1)));
      stale = out_valid && (out_pc[31:12] == 20'h00002);
      chk("no_stale_pc", {31'b0, stale}, 32'h0);
      settle();
    end

    // Back-to-back redirects: only the second target stream survives
    do_reset();
    repeat (3) begin drive(1'b1, 1'b0, 32'h0, 1'b1); settle(); end
    drive(1'b1, 1'b1, 32'h4000, 1'b1); settle();
    drive(1'b1, 1'b1, 32'h5000, 1'b1); settle();
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      if (out_valid === 1'b1) found = 1;
      else settle();
    end
    chk("dbl_redir_found", {31'b0, found}, 32'h1);
    chk("dbl_redir_pc0", out_pc, 32'h5000);
    settle();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("dbl_redir_pc1", out_pc, 32'h5004);
    settle();

    // Stall then flush 2 entries plus 1 in-flight read
    do_reset();
    obs_stall = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 32'h0, (i >= 8) ? 1'b1 : 1'b0);
      if (mem_req === 1'b0) obs_stall++;
      settle();
    end
    chk("observed_stall", 32'(obs_stall), 32'd5);
    drive(1'b1, 1'b1, 32'h6000, 1'b0);
    settle();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_QUEUE_PERF_EN
    chk("perf_flushed_3", perf_flushed, 32'd3);
    chk("perf_stall_obs", perf_stall, 32'(obs_stall));
    $display("perf: fetched=%0d flushed=%0d stall=%0d", perf_fetched, perf_flushed, perf_stall);
`endif
    settle();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rn  = ($urandom_range(0, 199) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      drive(rn, rd, rpc, rdy);
      settle();
    end

    // PC wrap of the second instance
    chk("wrap_captured", 32'(cap_pc.size()), 32'd4);
    exp_pc = 32'hFFFF_FFF8;
    for (int k = 0; k < 4 && k < cap_pc.size(); k++) begin
      chk("wrap_pc", cap_pc[k], exp_pc);
      chk("wrap_ir", cap_ir[k], imem(exp_pc));
      $display("wrap %0d: pc=%h ir=%h", k, cap_pc[k], cap_ir[k]);
      exp_pc = exp_pc + 32'd4;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
